// File: rtl/sr_latch_ctrl.sv
// sr_latch_ctrl: round-robin two-requester pulse controller for a shared SR latch.
// Optional per-bit request debounce is compiled in with `define SRCTL_DEBOUNCE_EN.
module sr_latch_ctrl #(
  parameter int PULSE_CYCLES    = 4,
  parameter int HOLDOFF_CYCLES  = 3,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic [1:0] req_set,
  input  logic [1:0] req_clr,
  input  logic       q_in,
  output logic       Sn,
  output logic       Rn,
  output logic [1:0] grant,
  output logic       busy,
  output logic       err
);
  typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} state_t;
  localparam logic [7:0] P_LD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] H_LD = 8'(HOLDOFF_CYCLES - 1);

  if (PULSE_CYCLES < 1 || PULSE_CYCLES > 255 || HOLDOFF_CYCLES < 2 || HOLDOFF_CYCLES > 255 ||
      DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_param
    $error("sr_latch_ctrl: parameter out of legal range");
  end

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] s1_q, s2_q, req_v;
  logic [1:0] grant_q, grant_d, pend, set_v, clr_v;
  logic       op_q, op_d, prio_q, prio_d, sn_q, sn_d, rn_q, rn_d;
  logic       busy_q, busy_d, err_q, err_d, win, accept;

  // bit layout {clr[1:0], set[1:0]}
  always_ff @(posedge CLOCK_50 or negedge RST_N)
    if (!RST_N) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= {req_clr, req_set};
      s2_q <= s1_q;
    end

`ifdef SRCTL_DEBOUNCE_EN
  localparam logic [15:0] DB_MAX = 16'(DEBOUNCE_CYCLES - 1);
  logic [3:0]  deb_q;
  logic [15:0] db_q [4];
  always_ff @(posedge CLOCK_50 or negedge RST_N)
    if (!RST_N) begin
      deb_q <= '0;
      for (int i = 0; i < 4; i++) db_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (s2_q[i] == deb_q[i]) db_q[i] <= '0;
        else if (db_q[i] == DB_MAX) begin
          deb_q[i] <= s2_q[i];
          db_q[i]  <= '0;
        end else db_q[i] <= db_q[i] + 16'd1;
    end
  assign req_v = deb_q;
`else
  assign req_v = s2_q;
`endif

  assign set_v  = req_v[1:0];
  assign clr_v  = req_v[3:2];
  assign pend   = set_v | clr_v;
  assign win    = (&pend) ? prio_q : pend[1];
  assign accept = (state_q == IDLE) && (|pend);

  always_ff @(posedge CLOCK_50 or negedge RST_N)
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      prio_q  <= 1'b0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      sn_q    <= 1'b1;
      rn_q    <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      prio_q  <= prio_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      sn_q    <= sn_d;
      rn_q    <= rn_d;
      err_q   <= err_d;
    end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
    if (accept) begin
      state_d = PULSE;
      cnt_d   = P_LD;
    end else if (state_q == PULSE && cnt_q == 8'd0) begin
      state_d = HOLDOFF;
      cnt_d   = H_LD;
    end else if (state_q == HOLDOFF && cnt_q == 8'd0) state_d = IDLE;
  end

  // op_q is 1 for a set; a simultaneous set and clear resolves to set
  always_comb begin
    op_d    = accept ? set_v[win] : op_q;
    prio_d  = accept ? ~win : prio_q;
    grant_d = accept ? (win ? 2'b10 : 2'b01) : 2'b00;
    busy_d  = state_d != IDLE;
    sn_d    = !(state_d == PULSE && op_d);
    rn_d    = !(state_d == PULSE && !op_d);
    err_d   = err_q | (state_q == HOLDOFF && cnt_q == 8'd0 && q_in != op_q);
  end

  assign Sn    = sn_q;
  assign Rn    = rn_q;
  assign grant = grant_q;
  assign busy  = busy_q;
  assign err   = err_q;
endmodule
